// File: rtl/rs232_rx_fifo.sv
// Receive-side byte FIFO between the RS-232 receiver handshake and the CPU IO read path.
// First-word-fall-through storage, explicit occupancy count and a sticky overrun flag.
module rs232_rx_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_rdy,
  input  logic [DW-1:0] in_data,
  output logic          in_done,
  input  logic          pop,
  input  logic          stat_rd,
  output logic [DW-1:0] dout,
  output logic          rdy,
  output logic [AW:0]   count,
  output logic          ovf
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } cap_state_t;

  cap_state_t state_reg, state_next;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wptr_reg, wptr_next;
  logic [AW-1:0] rptr_reg, rptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          ovf_reg, ovf_next;
  logic          in_done_reg, in_done_next;

  logic push_req;
  logic full;
  logic empty;
  logic pop_ok;
  logic push_ok;
  logic drop;

  // Capture FSM: one push request and one in_done pulse per receiver byte,
  // however long the receiver keeps rdy asserted afterwards.
  always_comb begin
    state_next   = state_reg;
    in_done_next = 1'b0;
    push_req     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_rdy) begin
          push_req     = 1'b1;
          in_done_next = 1'b1;
          state_next   = WAIT;
        end
      end
      WAIT: begin
        if (!in_rdy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push_req & (~full | pop_ok);
  assign drop    = push_req & full & ~pop_ok;

  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    if (push_ok) begin
      wptr_next = wptr_reg + 1'b1;
    end
    if (pop_ok) begin
      rptr_next = rptr_reg + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Set wins over a coincident status read so a drop is never lost.
  always_comb begin
    ovf_next = ovf_reg;
    if (drop) begin
      ovf_next = 1'b1;
    end else if (stat_rd) begin
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      count_reg   <= '0;
      ovf_reg     <= 1'b0;
      in_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wptr_reg    <= wptr_next;
      rptr_reg    <= rptr_next;
      count_reg   <= count_next;
      ovf_reg     <= ovf_next;
      in_done_reg <= in_done_next;
    end
  end

  // Storage contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_reg] <= in_data;
    end
  end

  assign dout    = mem[rptr_reg];
  assign rdy     = ~empty;
  assign count   = count_reg;
  assign ovf     = ovf_reg;
  assign in_done = in_done_reg;

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Directed bench for rs232_rx_fifo: a queue scoreboard holds the bytes expected
// at the FIFO head and is compared against dout/count/rdy/ovf after every step.
module tb_rs232_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_rdy;
  logic [7:0] in_data;
  logic       in_done;
  logic       pop;
  logic       stat_rd;
  logic [7:0] dout;
  logic       rdy;
  logic [4:0] count;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovf;

  rs232_rx_fifo #(.AW(4), .DW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_rdy  (in_rdy),
    .in_data (in_data),
    .in_done (in_done),
    .pop     (pop),
    .stat_rd (stat_rd),
    .dout    (dout),
    .rdy     (rdy),
    .count   (count),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the effect of one clock edge to the scoreboard.
  task automatic model_edge(input bit push, input logic [7:0] b, input bit pop_req, input bit srd);
    bit pop_ok;
    bit dropped;
    pop_ok  = pop_req && (exp_q.size() > 0);
    dropped = push && (exp_q.size() == 16) && !pop_ok;
    if (pop_ok) void'(exp_q.pop_front());
    if (push && !dropped) exp_q.push_back(b);
    if (dropped) exp_ovf = 1'b1;
    else if (srd) exp_ovf = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, ".rdy"}, 32'(rdy), 32'(exp_q.size() > 0));
    chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
    if (exp_q.size() > 0) chk({tag, ".dout"}, 32'(dout), 32'(exp_q[0]));
  endtask

  // One receiver byte: rdy high until in_done is seen, then released.
  task automatic send_byte(input logic [7:0] b, input bit with_pop, input bit srd);
    $display("tx byte %02h pop=%0d stat_rd=%0d", b, with_pop, srd);
    if (with_pop && exp_q.size() > 0) chk("send.head", 32'(dout), 32'(exp_q[0]));
    in_rdy  = 1'b1;
    in_data = b;
    pop     = with_pop;
    stat_rd = srd;
    step();
    model_edge(1'b1, b, with_pop, srd);
    pop     = 1'b0;
    stat_rd = 1'b0;
    chk("send.done_hi", 32'(in_done), 32'd1);
    in_rdy = 1'b0;
    step();
    chk("send.done_lo", 32'(in_done), 32'd0);
    check_state("send");
  endtask

  task automatic pop_byte();
    if (exp_q.size() > 0) begin
      chk("pop.rdy", 32'(rdy), 32'd1);
      chk("pop.data", 32'(dout), 32'(exp_q[0]));
      $display("rx byte %02h", dout);
    end
    pop = 1'b1;
    step();
    model_edge(1'b0, 8'h00, 1'b1, 1'b0);
    pop = 1'b0;
    check_state("pop");
  endtask

  initial begin
    int pulses;
    rst     = 1'b1;
    in_rdy  = 1'b0;
    in_data = 8'h00;
    pop     = 1'b0;
    stat_rd = 1'b0;
    exp_ovf = 1'b0;
    #23;
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.rdy", 32'(rdy), 32'd0);
    chk("reset.ovf", 32'(ovf), 32'd0);
    chk("reset.in_done", 32'(in_done), 32'd0);
    rst = 1'b0;
    step();

    // Single byte
    send_byte(8'h41, 1'b0, 1'b0);
    pop_byte();

    // Ordering across pointer wraps
    for (int i = 0; i < 40; i++) begin
      send_byte(8'(i), 1'b0, 1'b0);
      if (exp_q.size() >= 8) pop_byte();
    end
    while (exp_q.size() > 0) pop_byte();
    chk("wrap.ovf", 32'(ovf), 32'd0);

    // Overrun: 17th byte dropped, in_done still pulsed inside send_byte
    for (int i = 0; i < 17; i++) send_byte(8'(8'h10 + i), 1'b0, 1'b0);
    chk("ovr.count", 32'(count), 32'd16);
    chk("ovr.ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) pop_byte();
    stat_rd = 1'b1;
    step();
    model_edge(1'b0, 8'h00, 1'b0, 1'b1);
    stat_rd = 1'b0;
    check_state("stat_rd");

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 1'b0, 1'b0);
    send_byte(8'h99, 1'b1, 1'b0);
    chk("fullpp.count", 32'(count), 32'd16);
    chk("fullpp.ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 16; i++) pop_byte();
    chk("fullpp.drained", 32'(count), 32'd0);

    // Pop on empty
    pop_byte();
    chk("empty_pop.count", 32'(count), 32'd0);

    // in_rdy held high for 10 cycles
    pulses  = 0;
    in_rdy  = 1'b1;
    in_data = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) model_edge(1'b1, 8'h5A, 1'b0, 1'b0);
      if (in_done) pulses++;
    end
    in_rdy = 1'b0;
    step();
    if (in_done) pulses++;
    $display("held in_rdy: %0d in_done pulses", pulses);
    chk("held.pulses", 32'(pulses), 32'd1);
    check_state("held");
    pop_byte();

    // stat_rd coincident with a dropped push
    for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i), 1'b0, 1'b0);
    send_byte(8'hEE, 1'b0, 1'b1);
    chk("ovf_vs_stat.ovf", 32'(ovf), 32'd1);

    // Async reset with count=5 and capture FSM in WAIT
    for (int i = 0; i < 12; i++) pop_byte();
    in_rdy  = 1'b1;
    in_data = 8'hC5;
    step();
    model_edge(1'b1, 8'hC5, 1'b0, 1'b0);
    chk("prereset.count", 32'(count), 32'd5);
    chk("prereset.in_done", 32'(in_done), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async.count", 32'(count), 32'd0);
    chk("async.rdy", 32'(rdy), 32'd0);
    chk("async.ovf", 32'(ovf), 32'd0);
    chk("async.in_done", 32'(in_done), 32'd0);
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    rst     = 1'b0;
    in_data = 8'h77;
    step();
    model_edge(1'b1, 8'h77, 1'b0, 1'b0);
    chk("post_reset.in_done", 32'(in_done), 32'd1);
    in_rdy = 1'b0;
    step();
    chk("post_reset.done_lo", 32'(in_done), 32'd0);
    check_state("post_reset");
    pop_byte();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
